// File: rtl/conv_mac_pipe.sv
// Pipelined signed multiply-accumulate over first/last-delimited windows.
// Define CONV_MAC_SAT_EN to clamp the accumulator and report ovf instead of wrapping.
module conv_mac_pipe #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          NUM_STAGE  = 3,
  parameter int          din0_WIDTH = 16,
  parameter int          din1_WIDTH = 8,
  parameter int          dout_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         first,
  input  logic                         last,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         out_valid,
  output logic                         ovf
);

  localparam int MS = NUM_STAGE - 1;
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int W  = dout_WIDTH;

  // ID is informational only and never changes the hardware.
  if (ID == 32'd0) begin : g_id_zero
  end

  logic signed [PW-1:0] prod_full;
  logic signed [W-1:0]  prod_ext;
  logic signed [W-1:0]  prod_q [MS];
  logic [MS-1:0]        vld_q;
  logic [MS-1:0]        first_q;
  logic [MS-1:0]        last_q;

  always_comb begin
    prod_full          = din0 * din1;
    prod_ext           = {W{prod_full[PW-1]}};
    prod_ext[PW-1:0]   = prod_full;
  end

  // Sideband is masked by in_valid so a bubble can never open or close a window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < MS; i++) prod_q[i] <= '0;
    end else if (ce) begin
      vld_q[0]   <= in_valid;
      first_q[0] <= in_valid & first;
      last_q[0]  <= in_valid & last;
      prod_q[0]  <= prod_ext;
      for (int i = 1; i < MS; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
        prod_q[i]  <= prod_q[i-1];
      end
    end
  end

  logic signed [W-1:0] acc;
  logic signed [W-1:0] p;
  logic signed [W-1:0] sum;
  logic [W:0]          add_full;
  logic                win_open;
  logic                win_ovf;
  logic                start;
  logic                clamp;

  always_comb begin
    p        = prod_q[MS-1];
    start    = first_q[MS-1] | ~win_open;
    add_full = {acc[W-1], acc} + {p[W-1], p};
    sum      = add_full[W-1:0];
    clamp    = 1'b0;
`ifdef CONV_MAC_SAT_EN
    if (add_full[W] != add_full[W-1]) begin
      clamp = 1'b1;
      sum   = add_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    // A single product always fits, so a window start never clamps.
    if (start) begin
      sum   = p;
      clamp = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      win_open  <= 1'b0;
      win_ovf   <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= 1'b0;
      if (vld_q[MS-1]) begin
        acc      <= sum;
        win_open <= ~last_q[MS-1];
        win_ovf  <= (win_ovf & ~start) | clamp;
        if (last_q[MS-1]) begin
          dout      <= sum;
          out_valid <= 1'b1;
          ovf       <= (win_ovf & ~start) | clamp;
        end
      end
    end
  end

endmodule
